// File: rtl/fc_layer_seq.sv
// Fully-connected layer sequencer: streams weight/activation chunks through an external MultAdd,
// accumulates, adds bias and requantises to int8. Define FC_RELU_EN to write negative outputs as 0.
module fc_layer_seq #(
  parameter int          LANES  = 128,
  parameter int          N_IN   = 256,
  parameter int          N_OUT  = 128,
  parameter int          ADDR_W = 12,
  parameter int unsigned W_BASE = 'h400,
  parameter int unsigned A_BASE = 'h000,
  parameter int unsigned B_BASE = 'h600,
  parameter int          SHIFT  = 4
) (
  input  logic                 clk,
  input  logic                 iRst_n,
  input  logic                 start,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [LANES*8-1:0]   mem_rdata,
  output logic [LANES*8-1:0]   mac_a,
  output logic [LANES*8-1:0]   mac_b,
  input  logic [15:0]          mac_res,
  input  logic                 mac_ovf,
  output logic [N_OUT*8-1:0]   result,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int CHUNKS = N_IN / LANES;
  localparam int JW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int VW     = 18 + SHIFT;
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);
  localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ASK_W, S_ASK_A, S_LOAD_A, S_ACC, S_ASK_B, S_GET_B, S_WRITE, S_DONE
  } state_t;

  state_t               state;
  logic [JW-1:0]        j;
  logic [KW-1:0]        k;
  logic signed [15:0]   acc;
  logic signed [7:0]    bias;

  logic signed [16:0]   acc_sum;
  logic signed [15:0]   acc_clamped;
  logic                 acc_clip;
  logic signed [VW-1:0] v_wide;
  logic signed [15:0]   v;
  logic                 v_clip;
  logic signed [15:0]   v_shr;
  logic signed [7:0]    q;
  logic                 q_clip;
  logic signed [7:0]    q_out;

  function automatic logic [ADDR_W-1:0] w_addr(input logic [JW-1:0] jj, input logic [KW-1:0] kk);
    return ADDR_W'(W_BASE + int'(jj) * CHUNKS + int'(kk));
  endfunction

  function automatic logic [ADDR_W-1:0] a_addr(input logic [KW-1:0] kk);
    return ADDR_W'(A_BASE + int'(kk));
  endfunction

  function automatic logic [ADDR_W-1:0] b_addr(input logic [JW-1:0] jj);
    return ADDR_W'(B_BASE + int'(jj) / LANES);
  endfunction

  // Saturation is detected from redundant sign bits rather than magnitude compares.
  always_comb begin
    acc_sum     = {acc[15], acc} + {mac_res[15], mac_res};
    acc_clip    = acc_sum[16] != acc_sum[15];
    acc_clamped = acc_clip ? (acc_sum[16] ? 16'sh8000 : 16'sh7FFF) : acc_sum[15:0];

    v_wide = {{(VW-16){acc[15]}}, acc} + ({{(VW-8){bias[7]}}, bias} <<< SHIFT);
    v_clip = !((&v_wide[VW-1:15]) || !(|v_wide[VW-1:15]));
    v      = v_clip ? (v_wide[VW-1] ? 16'sh8000 : 16'sh7FFF) : v_wide[15:0];

    v_shr  = v >>> SHIFT;
    q_clip = !((&v_shr[15:7]) || !(|v_shr[15:7]));
    q      = q_clip ? (v_shr[15] ? 8'sh80 : 8'sh7F) : v_shr[7:0];
`ifdef FC_RELU_EN
    q_out  = q[7] ? '0 : q;
`else
    q_out  = q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      state    <= S_IDLE;
      j        <= '0;
      k        <= '0;
      acc      <= '0;
      bias     <= '0;
      mem_addr <= '0;
      mac_a    <= '0;
      mac_b    <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b1;
            mem_addr <= w_addr('0, '0);
            state    <= S_ASK_W;
          end
        end
        S_ASK_W: begin
          mem_addr <= a_addr(k);
          state    <= S_ASK_A;
        end
        S_ASK_A: begin
          mac_a <= mem_rdata;
          state <= S_LOAD_A;
        end
        S_LOAD_A: begin
          mac_b <= mem_rdata;
          state <= S_ACC;
        end
        S_ACC: begin
          acc <= acc_clamped;
          if (mac_ovf || acc_clip) overflow <= 1'b1;
          if (k == K_LAST) begin
            k        <= '0;
            mem_addr <= b_addr(j);
            state    <= S_ASK_B;
          end else begin
            k        <= k + 1'b1;
            mem_addr <= w_addr(j, k + 1'b1);
            state    <= S_ASK_W;
          end
        end
        S_ASK_B: state <= S_GET_B;
        S_GET_B: begin
          bias  <= mem_rdata[8*(int'(j) % LANES) +: 8];
          state <= S_WRITE;
        end
        S_WRITE: begin
          result[8*int'(j) +: 8] <= q_out;
          acc <= '0;
          if (v_clip || q_clip) overflow <= 1'b1;
          if (j == J_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            j        <= j + 1'b1;
            mem_addr <= w_addr(j + 1'b1, '0);
            state    <= S_ASK_W;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
